cordic_iter_ctrl: RTL and testbench
===================================

# cordic_iter_ctrl

Iteration sequencer for the circular CORDIC rotation datapath. Accepts a target angle on a start handshake, loads the angle-residual register, then steps the datapath through `ITER` micro-rotations. Each step supplies the arctangent constant and shift amount for that step. Signals completion with a one-cycle `done` pulse. It drives the load strobe, `alpha_i` and the shift index consumed by the delta generator and the X/Y shift-add stages.

## Interface
- `WIDTH`, 16: angle/datapath word width; angles are two's complement with scale 2^(WIDTH-3) per radian.
- `ITER`, 16: number of micro-rotations; legal range 1..WIDTH.
- `IW`, $clog2(ITER): iteration index width.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only in IDLE.
- `theta_in`  in  WIDTH  target angle; sampled on the accepted start.
- `delta`  in  1  sign of the current residual (1 = negative), from the delta generator.
- `theta`  out  WIDTH  registered angle driven to the residual register's load input.
- `load`  out  1  one-cycle load strobe to the residual and X/Y registers.
- `step_en`  out  1  high on each iteration cycle; enables datapath register update.
- `iter`  out  IW  current iteration index i.
- `alpha_i`  out  WIDTH  atan(2^-i) constant for the current i.
- `shift`  out  IW  shift amount for X/Y cross terms; equals `iter`.
- `dir`  out  1  registered copy of `delta` from the last step (debug/monitor).
- `busy`  out  1  high in LOAD, ITER and DONE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, LOAD, ITER, DONE.
  - IDLE: `start`=1 moves to LOAD and captures `theta_in` into `theta`.
  - LOAD: `load`=1 for one cycle; clears the counter; next state is ITER.
  - ITER: `step_en`=1; `iter` counts 0..ITER-1; on the cycle with `iter`=ITER-1 the next state is DONE.
  - DONE: `done`=1 for one cycle; next state is IDLE.
- `alpha_i` = ROM[`iter`], combinational from the registered index, so it is valid in the same cycle as `step_en`.
- ROM entry i = round(atan(2^-i)·2^(WIDTH-3)). For WIDTH=16: i=0 is 6434, i=1 is 3798, i=2 is 2007.
- Outside ITER, `alpha_i` = 0 and `shift` = 0.
- `dir` updates from `delta` on every ITER cycle and holds otherwise.
- `start` outside IDLE (including the DONE cycle) is ignored; no queuing.
- `theta` holds its value until the next accepted start.
- Reset values: state IDLE; `theta`, `iter`, `shift`, `alpha_i` = 0; `load`, `step_en`, `busy`, `done`, `dir` = 0.
- Reset asserted mid-operation returns the block to IDLE on that edge with no `done` pulse.
- Reset dominates `start` in the same cycle.

## Timing
- Start accepted at edge T0 gives:
  - LOAD during T0..T1.
  - ITER during cycles T1..T(ITER).
  - `done` high in cycle T(ITER+1).
- `busy` falls the cycle after `done`.
- Latency from start acceptance to `done` is ITER+1 cycles; issue interval is ITER+3 cycles.
- `step_en`, `iter` and `alpha_i` are mutually aligned. The datapath registers update at the edge that ends each ITER cycle.

## Configuration
- `CORDIC_ABORT_EN`, when defined, adds input `abort` (1 bit) and output `aborted` (1 bit, one-cycle pulse).
  - `abort`=1 in LOAD or ITER forces IDLE on the next edge and pulses `aborted`; `done` is not asserted.
  - `abort` in IDLE or DONE is ignored.
- When not defined, neither port exists and operations always run to completion.

## Structure
- Shared package `cordic_pkg` holds:
  - state enum `cordic_state_t`;
  - angle scale constant `CORDIC_ANGLE_FRAC` = WIDTH-3;
  - function `cordic_atan(i, width)` returning the rounded table value.
- One sub-module, `cordic_atan_rom`:
  - parameters WIDTH and ITER;
  - combinational, index in, `alpha_i` out;
  - entries built from the package function.
- Counter and FSM stay in the top module.

## Test plan
- Reset, then idle 5 cycles: all outputs 0, `busy`=0.
- WIDTH=16, ITER=16, `start` with `theta_in`=4289 (≈0.5236 rad): `load` pulses one cycle later; `step_en` is high for 16 cycles with `alpha_i` = 6434, 3798, 2007, … matching `iter` 0..15; `done` pulses at start+17.
- `start` held high continuously: operations issue every 19 cycles; no start is accepted while `busy`=1, including in the DONE cycle.
- `rst` asserted at `iter`=7: next cycle is IDLE, all outputs at reset values, no `done` pulse; a fresh start then completes normally.
- ITER=1: one ITER cycle with `alpha_i`=6434, `done` two cycles after acceptance.
- With `CORDIC_ABORT_EN` defined, `abort` at `iter`=3: `aborted` pulses, no `done`, `busy` low next cycle; `abort` asserted in IDLE has no effect.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC types and helpers: FSM state enum, angle scaling, and the
// elaboration-time arctangent table generator.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } cordic_state_t;

  localparam int CORDIC_WIDTH      = 16;
  localparam int CORDIC_FRAC_OFF   = 3;
  localparam int CORDIC_ANGLE_FRAC = CORDIC_WIDTH - CORDIC_FRAC_OFF;

  // round(atan(2^-i) * 2^(width-3)); atan is evaluated in Q60 (pi/4 directly,
  // otherwise the alternating Taylor series, which converges for i >= 1).
  function automatic logic [63:0] cordic_atan(input int i, input int width);
    logic [63:0] acc;
    logic [63:0] term;
    int          sh;
    acc = '0;
    if (i == 0) begin
      acc = 64'h0C90_FDAA_2216_8C23;
    end else begin
      for (int k = 0; k < 32; k++) begin
        sh = i * (2 * k + 1);
        if (sh <= 60) begin
          term = (64'd1 << (60 - sh)) / 64'(2 * k + 1);
          if (k % 2 == 0) acc = acc + term;
          else            acc = acc - term;
        end
      end
    end
    return (acc + (64'd1 << (60 - (width - CORDIC_FRAC_OFF) - 1)))
           >> (60 - (width - CORDIC_FRAC_OFF));
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent constant table indexed by the CORDIC iteration.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 16,
  parameter int IW    = (ITER > 1) ? $clog2(ITER) : 1
) (
  input  logic [IW-1:0]    idx,
  output logic [WIDTH-1:0] alpha
);

  logic [WIDTH-1:0] rom [2**IW];

  // Rows past ITER-1 are unreachable; tie them off so the table is a full power of two.
  for (genvar g = 0; g < 2**IW; g++) begin : g_rom
    if (g < ITER) begin : g_used
      assign rom[g] = WIDTH'(cordic_atan(g, WIDTH));
    end else begin : g_pad
      assign rom[g] = '0;
    end
  end

  assign alpha = rom[idx];

endmodule

// File: rtl/cordic_iter_ctrl.sv
// CORDIC rotation iteration sequencer: IDLE -> LOAD -> ITER x N -> DONE.
// Optional abort port pair is enabled by defining CORDIC_ABORT_EN.
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int WIDTH = CORDIC_WIDTH,
  parameter int ITER  = 16,
  parameter int IW    = (ITER > 1) ? $clog2(ITER) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] theta_in,
  input  logic             delta,
`ifdef CORDIC_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [WIDTH-1:0] theta,
  output logic             load,
  output logic             step_en,
  output logic [IW-1:0]    iter,
  output logic [WIDTH-1:0] alpha_i,
  output logic [IW-1:0]    shift,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // start is a request sampled only in IDLE; there is no ready/queue, a start
  // seen in any other state (including DONE) is simply dropped.
  cordic_state_t    state;
  logic [IW-1:0]    cnt;
  logic [WIDTH-1:0] rom_alpha;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      theta <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
`ifdef CORDIC_ABORT_EN
      aborted <= 1'b0;
`endif
    end else begin
`ifdef CORDIC_ABORT_EN
      aborted <= 1'b0;
`endif
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_LOAD;
          theta <= theta_in;
        end
        ST_LOAD: begin
          cnt   <= '0;
          state <= ST_ITER;
        end
        ST_ITER: begin
          dir <= delta;
          // Counter returns to 0 after the last step so iter reads 0 when idle.
          if (cnt == IW'(ITER - 1)) begin
            cnt   <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
`ifdef CORDIC_ABORT_EN
      if (abort && (state == ST_LOAD || state == ST_ITER)) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        aborted <= 1'b1;
      end
`endif
    end
  end

  cordic_atan_rom #(.WIDTH(WIDTH), .ITER(ITER), .IW(IW)) u_rom (
    .idx   (cnt),
    .alpha (rom_alpha)
  );

  assign load      = (state == ST_LOAD);
  assign step_en   = (state == ST_ITER);
  assign done      = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign iter      = cnt;
  assign shift     = step_en ? cnt : '0;
  assign alpha_i   = step_en ? rom_alpha : '0;
  assign state_dbg = state;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl: an ITER=16 and an ITER=1 instance share stimulus,
// each tracked by a phase-count reference model.
module tb_cordic_iter_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start, delta, abort_drv;
  logic [W-1:0] theta_in;

  always #5 clk = ~clk;

  logic [W-1:0] theta0, alpha0, theta1, alpha1;
  logic         load0, step0, dir0, busy0, done0, load1, step1, dir1, busy1, done1;
  logic [3:0]   iter0, shift0;
  logic [0:0]   iter1, shift1;
  logic [1:0]   st0, st1;
  logic         aborted0, aborted1;

  cordic_iter_ctrl #(.WIDTH(W), .ITER(16)) dut0 (
    .clk(clk), .rst(rst), .start(start), .theta_in(theta_in), .delta(delta),
`ifdef CORDIC_ABORT_EN
    .abort(abort_drv), .aborted(aborted0),
`endif
    .theta(theta0), .load(load0), .step_en(step0), .iter(iter0), .alpha_i(alpha0),
    .shift(shift0), .dir(dir0), .busy(busy0), .done(done0), .state_dbg(st0)
  );

  cordic_iter_ctrl #(.WIDTH(W), .ITER(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .theta_in(theta_in), .delta(delta),
`ifdef CORDIC_ABORT_EN
    .abort(abort_drv), .aborted(aborted1),
`endif
    .theta(theta1), .load(load1), .step_en(step1), .iter(iter1), .alpha_i(alpha1),
    .shift(shift1), .dir(dir1), .busy(busy1), .done(done1), .state_dbg(st1)
  );

`ifndef CORDIC_ABORT_EN
  assign aborted0 = 1'b0;
  assign aborted1 = 1'b0;
`endif

  // Reference model: k = edges since start acceptance (-1 when idle).
  // k=0 LOAD, k=1..N step with i=k-1, k=N+1 done.
  int           iters [2] = '{16, 1};
  int           k_m   [2];
  logic [W-1:0] theta_m [2];
  logic         dir_m [2];
  logic         ab_m  [2];
  int           atan_tab [16];
  int           passed = 0, total = 0, cyc = 0;

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s dut%0d cyc%0d: got %0d expected %0d", tag, d, cyc, obs, exp);
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        k_m[d] = -1; theta_m[d] = '0; dir_m[d] = 1'b0; ab_m[d] = 1'b0;
      end else begin
        ab_m[d] = 1'b0;
        if (k_m[d] < 0) begin
          if (start) begin k_m[d] = 0; theta_m[d] = theta_in; end
        end else begin
          if (k_m[d] >= 1 && k_m[d] <= iters[d]) dir_m[d] = delta;
          if (abort_drv && k_m[d] <= iters[d]) begin
            k_m[d] = -1; ab_m[d] = 1'b1;
          end else if (k_m[d] == iters[d] + 1) k_m[d] = -1;
          else k_m[d] = k_m[d] + 1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic        stp;
    logic [31:0] i_exp;
    for (int d = 0; d < 2; d++) begin
      stp   = (k_m[d] >= 1 && k_m[d] <= iters[d]);
      i_exp = stp ? 32'(k_m[d] - 1) : 32'd0;
      chk("theta",   d, 32'(d == 0 ? theta0 : theta1), 32'(theta_m[d]));
      chk("load",    d, 32'(d == 0 ? load0 : load1), 32'(k_m[d] == 0));
      chk("step_en", d, 32'(d == 0 ? step0 : step1), 32'(stp));
      chk("iter",    d, d == 0 ? 32'(iter0) : 32'(iter1), i_exp);
      chk("shift",   d, d == 0 ? 32'(shift0) : 32'(shift1), i_exp);
      chk("alpha_i", d, 32'(d == 0 ? alpha0 : alpha1), stp ? 32'(atan_tab[i_exp]) : 32'd0);
      chk("dir",     d, 32'(d == 0 ? dir0 : dir1), 32'(dir_m[d]));
      chk("busy",    d, 32'(d == 0 ? busy0 : busy1), 32'(k_m[d] >= 0));
      chk("done",    d, 32'(d == 0 ? done0 : done1), 32'(k_m[d] == iters[d] + 1));
      chk("aborted", d, 32'(d == 0 ? aborted0 : aborted1), 32'(ab_m[d]));
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) atan_tab[i] = int'($atan(2.0 ** (-i)) * 8192.0);
    rst = 1'b1; start = 1'b0; delta = 1'b0; theta_in = '0; abort_drv = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    repeat (5) cycle();

    // Single directed operation at 30 degrees.
    theta_in = W'(4289); start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (20) begin delta = 1'($urandom_range(0, 1)); cycle(); end

    // start held high: back-to-back issue, drops while busy.
    start = 1'b1;
    repeat (60) begin theta_in = W'($urandom); delta = 1'($urandom_range(0, 1)); cycle(); end
    start = 1'b0;
    repeat (3) cycle();

    // Reset mid-operation at iter=7, then a fresh operation.
    theta_in = W'($urandom); start = 1'b1;
    cycle();
    start = 1'b0;
    for (int n = 0; n < 30 && k_m[0] != 8; n++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (3) cycle();
    theta_in = W'($urandom); start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (20) begin delta = 1'($urandom_range(0, 1)); cycle(); end

`ifdef CORDIC_ABORT_EN
    // Abort at iter=3, then abort while idle.
    theta_in = W'($urandom); start = 1'b1;
    cycle();
    start = 1'b0;
    for (int n = 0; n < 30 && k_m[0] != 4; n++) cycle();
    abort_drv = 1'b1;
    cycle();
    abort_drv = 1'b0;
    repeat (3) cycle();
    abort_drv = 1'b1;
    repeat (3) cycle();
    abort_drv = 1'b0;
`endif

    // Randomized traffic.
    repeat (300) begin
      start    = ($urandom_range(0, 3) == 0);
      theta_in = W'($urandom);
      delta    = 1'($urandom_range(0, 1));
      rst      = ($urandom_range(0, 63) == 0);
`ifdef CORDIC_ABORT_EN
      abort_drv = ($urandom_range(0, 15) == 0);
`endif
      cycle();
    end
    rst = 1'b0; start = 1'b0; abort_drv = 1'b0;
    repeat (20) cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
